fp_addsub_pipe: RTL

- Parametrised, pipelined IEEE-754 floating-point adder/subtractor for the vector accelerator ALU lanes.
- Generalises the combinational single-precision add/sub unit in four ways:
  - configurable exponent and mantissa widths;
  - a 3-stage pipeline with valid/ready flow control;
  - round-to-nearest-even;
  - full special-value handling with a 5-bit exception flag vector instead of a single zeroing flag.
- Accepts one operation per cycle and sits between the lane operand registers and the writeback buffer.

---
 rtl/fp_addsub_pipe.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: three-stage IEEE-754 adder/subtractor with configurable
// exponent/mantissa widths, round-to-nearest-even and a 5-bit flag vector
// {invalid, overflow, underflow, inexact, zero}. The whole pipe advances
// together whenever the output register is empty or being drained.
module fp_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int FP_W = 1 + EXP_W + MAN_W
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [FP_W-1:0] a_i,
    input  logic [FP_W-1:0] b_i,
    input  logic            sub_i,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [FP_W-1:0] result_o,
    output logic [4:0]      flags_o
);
    // Significand field: {hidden, mantissa, guard, round, sticky}
    localparam int SW      = MAN_W + 4;
    localparam int EXP_MAX = (1 << EXP_W) - 1;

    logic w_advance;
    assign w_advance = out_ready | ~out_valid;
    assign in_ready  = w_advance;

    // Operand unpack and classification
    logic             w_aSign, w_bSign;
    logic [EXP_W-1:0] w_aExp, w_bExp;
    logic [MAN_W-1:0] w_aMan, w_bMan;
    logic             w_aNan, w_bNan, w_aInf, w_bInf, w_aSnan, w_bSnan, w_infInf;

    assign w_aSign  = a_i[FP_W-1];
    assign w_bSign  = b_i[FP_W-1] ^ sub_i;
    assign w_aExp   = a_i[FP_W-2:MAN_W];
    assign w_bExp   = b_i[FP_W-2:MAN_W];
    assign w_aMan   = a_i[MAN_W-1:0];
    assign w_bMan   = b_i[MAN_W-1:0];
    assign w_aNan   = (&w_aExp) & (|w_aMan);
    assign w_bNan   = (&w_bExp) & (|w_bMan);
    assign w_aInf   = (&w_aExp) & ~(|w_aMan);
    assign w_bInf   = (&w_bExp) & ~(|w_bMan);
    assign w_aSnan  = w_aNan & ~w_aMan[MAN_W-1];
    assign w_bSnan  = w_bNan & ~w_bMan[MAN_W-1];
    assign w_infInf = w_aInf & w_bInf & (w_aSign ^ w_bSign);

    // Order operands so the larger magnitude is always on the L side
    logic             w_swap, w_lSign, w_sSign;
    logic [EXP_W-1:0] w_lExp, w_sExp, w_lExpEff, w_sExpEff, w_diff;
    logic [MAN_W-1:0] w_lMan, w_sMan;
    logic [SW-1:0]    w_lSig, w_sSigFull, w_sAligned, w_lostMask;
    logic [31:0]      w_shAmt;

    assign w_swap     = {w_bExp, w_bMan} > {w_aExp, w_aMan};
    assign w_lSign    = w_swap ? w_bSign : w_aSign;
    assign w_sSign    = w_swap ? w_aSign : w_bSign;
    assign w_lExp     = w_swap ? w_bExp  : w_aExp;
    assign w_sExp     = w_swap ? w_aExp  : w_bExp;
    assign w_lMan     = w_swap ? w_bMan  : w_aMan;
    assign w_sMan     = w_swap ? w_aMan  : w_bMan;
    assign w_lExpEff  = (w_lExp == '0) ? {{(EXP_W-1){1'b0}}, 1'b1} : w_lExp;
    assign w_sExpEff  = (w_sExp == '0) ? {{(EXP_W-1){1'b0}}, 1'b1} : w_sExp;
    assign w_diff     = w_lExpEff - w_sExpEff;
    assign w_shAmt    = 32'(w_diff);
    assign w_lSig     = {(w_lExp != '0), w_lMan, 3'b000};
    assign w_sSigFull = {(w_sExp != '0), w_sMan, 3'b000};

    // Align the smaller significand, folding every shifted-out bit into sticky
    always_comb begin
        w_lostMask = '0;
        w_sAligned = '0;
        if (w_shAmt >= 32'(SW)) begin
            w_sAligned = {{(SW-1){1'b0}}, |w_sSigFull};
        end else begin
            w_lostMask = ~({SW{1'b1}} << w_shAmt);
            w_sAligned = (w_sSigFull >> w_shAmt)
                       | {{(SW-1){1'b0}}, |(w_sSigFull & w_lostMask)};
        end
    end

    logic             r_s1Valid, r_s1Sign, r_s1EffSub, r_s1ZeroSign;
    logic             r_s1Nan, r_s1Invalid, r_s1Inf, r_s1InfSign;
    logic [EXP_W-1:0] r_s1Exp;
    logic [SW-1:0]    r_s1LSig, r_s1SSig;

    // Stage 1 register: aligned operands plus special-value classification
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_s1Valid    <= 1'b0;
            r_s1Sign     <= 1'b0;
            r_s1EffSub   <= 1'b0;
            r_s1ZeroSign <= 1'b0;
            r_s1Nan      <= 1'b0;
            r_s1Invalid  <= 1'b0;
            r_s1Inf      <= 1'b0;
            r_s1InfSign  <= 1'b0;
            r_s1Exp      <= '0;
            r_s1LSig     <= '0;
            r_s1SSig     <= '0;
        end else if (w_advance) begin
            r_s1Valid    <= in_valid;
            r_s1Sign     <= w_lSign;
            r_s1EffSub   <= w_lSign ^ w_sSign;
            r_s1ZeroSign <= w_lSign & w_sSign;
            r_s1Nan      <= w_aNan | w_bNan | w_infInf;
            r_s1Invalid  <= w_infInf | w_aSnan | w_bSnan;
            r_s1Inf      <= w_aInf | w_bInf;
            r_s1InfSign  <= w_aInf ? w_aSign : w_bSign;
            r_s1Exp      <= w_lExpEff;
            r_s1LSig     <= w_lSig;
            r_s1SSig     <= w_sAligned;
        end
    end

    logic [SW:0] w_sum;
    assign w_sum = r_s1EffSub ? ({1'b0, r_s1LSig} - {1'b0, r_s1SSig})
                              : ({1'b0, r_s1LSig} + {1'b0, r_s1SSig});

    logic             r_s2Valid, r_s2Sign, r_s2ZeroSign;
    logic             r_s2Nan, r_s2Invalid, r_s2Inf, r_s2InfSign;
    logic [EXP_W-1:0] r_s2Exp;
    logic [SW:0]      r_s2Sum;

    // Stage 2 register: raw magnitude sum/difference with its carry bit
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_s2Valid    <= 1'b0;
            r_s2Sign     <= 1'b0;
            r_s2ZeroSign <= 1'b0;
            r_s2Nan      <= 1'b0;
            r_s2Invalid  <= 1'b0;
            r_s2Inf      <= 1'b0;
            r_s2InfSign  <= 1'b0;
            r_s2Exp      <= '0;
            r_s2Sum      <= '0;
        end else if (w_advance) begin
            r_s2Valid    <= r_s1Valid;
            r_s2Sign     <= r_s1Sign;
            r_s2ZeroSign <= r_s1ZeroSign;
            r_s2Nan      <= r_s1Nan;
            r_s2Invalid  <= r_s1Invalid;
            r_s2Inf      <= r_s1Inf;
            r_s2InfSign  <= r_s1InfSign;
            r_s2Exp      <= r_s1Exp;
            r_s2Sum      <= w_sum;
        end
    end

    logic [31:0]      w_lzc, w_maxShift, w_shift, w_normExp, w_expFinal;
    logic [SW-1:0]    w_norm;
    logic [MAN_W+1:0] w_rounded;
    logic [MAN_W-1:0] w_manFinal;
    logic             w_roundUp, w_inexact, w_sumZero;
    logic [FP_W-1:0]  w_result;
    logic [4:0]       w_flags;

    // Normalise, round to nearest even, then pick special or finite result
    always_comb begin
        w_lzc      = 32'(SW);
        w_maxShift = 32'(r_s2Exp) - 32'd1;
        w_shift    = '0;
        w_norm     = '0;
        w_normExp  = '0;
        w_expFinal = '0;
        w_manFinal = '0;
        w_result   = '0;
        w_flags    = '0;
        w_sumZero  = ~(|r_s2Sum);
        for (int i = 0; i < SW; i++) begin
            if (r_s2Sum[i]) w_lzc = 32'(SW - 1 - i);
        end
        if (r_s2Sum[SW]) begin
            w_norm    = {r_s2Sum[SW:2], r_s2Sum[1] | r_s2Sum[0]};
            w_normExp = 32'(r_s2Exp) + 32'd1;
        end else begin
            w_shift   = (w_lzc > w_maxShift) ? w_maxShift : w_lzc;
            w_norm    = r_s2Sum[SW-1:0] << w_shift;
            w_normExp = 32'(r_s2Exp) - w_shift;
        end
        w_roundUp = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
        w_inexact = |w_norm[2:0];
        w_rounded = {1'b0, w_norm[SW-1:3]} + {{(MAN_W+1){1'b0}}, w_roundUp};
        if (w_rounded[MAN_W+1]) begin
            w_expFinal = w_normExp + 32'd1;
            w_manFinal = w_rounded[MAN_W:1];
        end else begin
            w_expFinal = w_rounded[MAN_W] ? w_normExp : 32'd0;
            w_manFinal = w_rounded[MAN_W-1:0];
        end
        if (r_s2Nan) begin
            w_result = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            w_flags  = {r_s2Invalid, 4'b0000};
        end else if (r_s2Inf) begin
            w_result = {r_s2InfSign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (w_sumZero) begin
            w_result = {r_s2ZeroSign, {(FP_W-1){1'b0}}};
            w_flags  = 5'b00001;
        end else if (w_expFinal >= 32'(EXP_MAX)) begin
            w_result = {r_s2Sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_flags  = 5'b01010;
        end else begin
            w_result = {r_s2Sign, w_expFinal[EXP_W-1:0], w_manFinal};
            w_flags  = {2'b00, (w_expFinal == 32'd0) & w_inexact, w_inexact, 1'b0};
        end
    end

    // Stage 3 register: the output holding register, cleared on bubbles
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            out_valid <= 1'b0;
            result_o  <= '0;
            flags_o   <= '0;
        end else if (w_advance) begin
            out_valid <= r_s2Valid;
            result_o  <= r_s2Valid ? w_result : '0;
            flags_o   <= r_s2Valid ? w_flags : 5'b00000;
        end
    end
endmodule
